// File: rtl/drive_track_sequencer.sv
// drive_track_sequencer
//   Keeps a track buffer in step with the drive head. The head track must be
//   stable for SETTLE_CYCLES before any host transfer starts; a dirty buffer
//   is written back (FLUSH) before the new track is read (LOAD). Each failed
//   transfer attempt (error ack or timeout) is retried up to MAX_RETRIES
//   times with a one-cycle request gap, after which the block parks in ERROR
//   until the image is unmounted.
//
// Build option
//   TRACK_WRITEBACK_EN : when defined, DRIVE_WE marks the buffer dirty and
//                        dirty buffers are flushed before a reload. When
//                        undefined, DIRTY and HOST_WR are tied low and FLUSH
//                        is never entered.
//
// Ports
//   CLK_14M, RESET     : clock, asynchronous active-high reset
//   DISK_MOUNTED       : image present; low forces IDLE
//   DRIVE_TRACK[6:0]   : head track from the drive
//   DRIVE_WE           : drive write strobe into the track buffer
//   TRACK_BUSY         : high except in READY
//   DISK_READY         : high only in READY
//   TRACK_LOADED[6:0]  : track currently held in the buffer
//   LOADED_VALID       : TRACK_LOADED is meaningful
//   DIRTY              : buffer modified since load
//   DISK_ERROR         : retries exhausted
//   HOST_RD / HOST_WR  : load / writeback request to host
//   LBA_TRACK[6:0]     : track of the current request
//   HOST_ACK, HOST_ERR : one-cycle completion pulse, error qualifier
//
// States
//   IDLE   | no image; waiting for DISK_MOUNTED
//   SETTLE | waiting for the head track to stay constant
//   FLUSH  | writing the dirty buffer back (HOST_WR)
//   LOAD   | reading the latched track (HOST_RD)
//   READY  | buffer matches head; drive may access it
//   ERROR  | retries exhausted; held until unmount

module drive_track_sequencer #(
    parameter int SETTLE_CYCLES  = 1400,
    parameter int TIMEOUT_CYCLES = 14000000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       CLK_14M,
    input  logic       RESET,
    input  logic       DISK_MOUNTED,
    input  logic [6:0] DRIVE_TRACK,
    input  logic       DRIVE_WE,
    output logic       TRACK_BUSY,
    output logic       DISK_READY,
    output logic [6:0] TRACK_LOADED,
    output logic       LOADED_VALID,
    output logic       DIRTY,
    output logic       DISK_ERROR,
    output logic       HOST_RD,
    output logic       HOST_WR,
    output logic [6:0] LBA_TRACK,
    input  logic       HOST_ACK,
    input  logic       HOST_ERR
);

`ifdef TRACK_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 2);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_FLUSH, S_LOAD, S_READY, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    latch_q, latch_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          gap_q, gap_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [6:0]    lba_q, lba_d;
    logic [6:0]    loaded_q, loaded_d;
    logic          valid_q, valid_d;
    logic          dirty_q, dirty_d;
    logic          err_q, err_d;

    always_ff @(posedge CLK_14M or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            latch_q  <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            retry_q  <= '0;
            gap_q    <= 1'b0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            lba_q    <= '0;
            loaded_q <= '0;
            valid_q  <= 1'b0;
            dirty_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            latch_q  <= latch_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            retry_q  <= retry_d;
            gap_q    <= gap_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            lba_q    <= lba_d;
            loaded_q <= loaded_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        latch_d  = latch_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        gap_d    = gap_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        lba_d    = lba_q;
        loaded_d = loaded_q;
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (DISK_MOUNTED) begin
                    state_d  = S_SETTLE;
                    latch_d  = DRIVE_TRACK;
                    settle_d = '0;
                end
            end

            S_SETTLE: begin
                if (DRIVE_TRACK != latch_q) begin
                    latch_d  = DRIVE_TRACK;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    tmo_d   = '0;
                    retry_d = '0;
                    gap_d   = 1'b0;
                    if (valid_q && (latch_q == loaded_q)) begin
                        state_d = S_READY;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else if (WB_EN && dirty_q) begin
                        state_d = S_FLUSH;
                        wr_d    = 1'b1;
                        lba_d   = loaded_q;
                    end else begin
                        state_d = S_LOAD;
                        rd_d    = 1'b1;
                        lba_d   = latch_q;
                    end
                end else if (settle_q != '1) begin
                    settle_d = settle_q + 1'b1;
                end
            end

            S_FLUSH, S_LOAD: begin
                if (gap_q) begin
                    // Re-issue after the one-cycle drop; acks here are ignored.
                    gap_d = 1'b0;
                    tmo_d = '0;
                    if (state_q == S_FLUSH) wr_d = 1'b1;
                    else                    rd_d = 1'b1;
                end else if (HOST_ACK && !HOST_ERR) begin
                    if (state_q == S_FLUSH) begin
                        // Writeback done: read the new track straight away.
                        wr_d    = 1'b0;
                        dirty_d = 1'b0;
                        state_d = S_LOAD;
                        rd_d    = 1'b1;
                        lba_d   = latch_q;
                        tmo_d   = '0;
                        retry_d = '0;
                    end else begin
                        rd_d     = 1'b0;
                        loaded_d = latch_q;
                        valid_d  = 1'b1;
                        state_d  = S_READY;
                        busy_d   = 1'b0;
                        ready_d  = 1'b1;
                    end
                end else if ((HOST_ACK && HOST_ERR) || (tmo_q == TMO_LAST)) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        gap_d   = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                    end
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_READY: begin
                if (WB_EN && DRIVE_WE) dirty_d = 1'b1;
                if (DRIVE_TRACK != loaded_q) begin
                    state_d  = S_SETTLE;
                    latch_d  = DRIVE_TRACK;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                end
            end

            S_ERROR: ;

            default: state_d = S_IDLE;
        endcase

        // Unmount wins over everything, including a pending flush.
        if (!DISK_MOUNTED) begin
            state_d  = S_IDLE;
            rd_d     = 1'b0;
            wr_d     = 1'b0;
            valid_d  = 1'b0;
            dirty_d  = 1'b0;
            err_d    = 1'b0;
            busy_d   = 1'b1;
            ready_d  = 1'b0;
            gap_d    = 1'b0;
            settle_d = '0;
            tmo_d    = '0;
            retry_d  = '0;
        end
    end

    assign TRACK_BUSY   = busy_q;
    assign DISK_READY   = ready_q;
    assign TRACK_LOADED = loaded_q;
    assign LOADED_VALID = valid_q;
    assign DISK_ERROR   = err_q;
    assign HOST_RD      = rd_q;
    assign LBA_TRACK    = lba_q;
`ifdef TRACK_WRITEBACK_EN
    assign DIRTY        = dirty_q;
    assign HOST_WR      = wr_q;
`else
    assign DIRTY        = 1'b0;
    assign HOST_WR      = 1'b0;
`endif

endmodule

// File: tb/tb_drive_track_sequencer.sv
module tb_drive_track_sequencer;

    logic       CLK_14M = 1'b0;
    logic       RESET;
    logic       DISK_MOUNTED;
    logic [6:0] DRIVE_TRACK;
    logic       DRIVE_WE;
    logic       TRACK_BUSY, DISK_READY, LOADED_VALID, DIRTY, DISK_ERROR;
    logic [6:0] TRACK_LOADED, LBA_TRACK;
    logic       HOST_RD, HOST_WR, HOST_ACK, HOST_ERR;

`ifdef TRACK_WRITEBACK_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    drive_track_sequencer #(
        .SETTLE_CYCLES (1400),
        .TIMEOUT_CYCLES(16),
        .MAX_RETRIES   (2)
    ) dut (
        .CLK_14M     (CLK_14M),
        .RESET       (RESET),
        .DISK_MOUNTED(DISK_MOUNTED),
        .DRIVE_TRACK (DRIVE_TRACK),
        .DRIVE_WE    (DRIVE_WE),
        .TRACK_BUSY  (TRACK_BUSY),
        .DISK_READY  (DISK_READY),
        .TRACK_LOADED(TRACK_LOADED),
        .LOADED_VALID(LOADED_VALID),
        .DIRTY       (DIRTY),
        .DISK_ERROR  (DISK_ERROR),
        .HOST_RD     (HOST_RD),
        .HOST_WR     (HOST_WR),
        .LBA_TRACK   (LBA_TRACK),
        .HOST_ACK    (HOST_ACK),
        .HOST_ERR    (HOST_ERR)
    );

    always #35 CLK_14M = ~CLK_14M;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_rises = 0;
    int wr_rises = 0;
    logic rd_p = 1'b0;
    logic wr_p = 1'b0;

    always @(negedge CLK_14M) begin
        if (HOST_RD && !rd_p) rd_rises <= rd_rises + 1;
        if (HOST_WR && !wr_p) wr_rises <= wr_rises + 1;
        rd_p <= HOST_RD;
        wr_p <= HOST_WR;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK_14M);
        #1;
    endtask

    task automatic wait_req(input int budget, output int n);
        n = 0;
        while (!(HOST_RD || HOST_WR) && n < budget) begin
            cyc(1);
            n++;
        end
        check_val("req_seen", 32'(HOST_RD | HOST_WR), 1);
    endtask

    task automatic ack(input logic err);
        HOST_ACK = 1'b1;
        HOST_ERR = err;
        cyc(1);
        HOST_ACK = 1'b0;
        HOST_ERR = 1'b0;
    endtask

    task automatic load_track(input logic [6:0] trk, input string tag);
        int n;
        DRIVE_TRACK = trk;
        wait_req(3000, n);
        check_val({tag, "_rd"}, 32'(HOST_RD), 1);
        check_val({tag, "_lba"}, 32'(LBA_TRACK), 32'(trk));
        ack(1'b0);
        check_val({tag, "_ready"}, 32'(DISK_READY), 1);
        check_val({tag, "_loaded"}, 32'(TRACK_LOADED), 32'(trk));
    endtask

    initial begin
        int n;
        int base_rd, base_wr;

        RESET = 1'b1;
        DISK_MOUNTED = 1'b0;
        DRIVE_TRACK = 7'd0;
        DRIVE_WE = 1'b0;
        HOST_ACK = 1'b0;
        HOST_ERR = 1'b0;
        #100;
        check_val("rst_busy", 32'(TRACK_BUSY), 1);
        check_val("rst_ready", 32'(DISK_READY), 0);
        check_val("rst_rd", 32'(HOST_RD), 0);
        check_val("rst_wr", 32'(HOST_WR), 0);
        check_val("rst_lba", 32'(LBA_TRACK), 0);
        check_val("rst_loaded", 32'(TRACK_LOADED), 0);
        check_val("rst_valid", 32'(LOADED_VALID), 0);
        check_val("rst_dirty", 32'(DIRTY), 0);
        check_val("rst_err", 32'(DISK_ERROR), 0);
        cyc(1);
        RESET = 1'b0;
        cyc(2);

        // First mount, track 0: request appears on the 1401st edge after mount.
        DISK_MOUNTED = 1'b1;
        wait_req(3000, n);
        check_val("mnt_latency", 32'(n), 1401);
        check_val("mnt_rd", 32'(HOST_RD), 1);
        check_val("mnt_lba", 32'(LBA_TRACK), 0);
        ack(1'b0);
        check_val("mnt_rd_drop", 32'(HOST_RD), 0);
        check_val("mnt_ready", 32'(DISK_READY), 1);
        check_val("mnt_busy", 32'(TRACK_BUSY), 0);
        check_val("mnt_loaded", 32'(TRACK_LOADED), 0);
        check_val("mnt_valid", 32'(LOADED_VALID), 1);

        // Stray ack while READY.
        ack(1'b0);
        check_val("stray_ready", 32'(DISK_READY), 1);
        check_val("stray_rd", 32'(HOST_RD), 0);

        // Track change leaves READY on the next edge.
        DRIVE_TRACK = 7'd3;
        cyc(1);
        check_val("chg_busy", 32'(TRACK_BUSY), 1);
        check_val("chg_ready", 32'(DISK_READY), 0);
        load_track(7'd3, "t3");

        // Wiggle 3->4->3: re-settles onto the loaded track, no transfer.
        base_rd = rd_rises;
        base_wr = wr_rises;
        DRIVE_TRACK = 7'd4;
        cyc(50);
        DRIVE_TRACK = 7'd3;
        cyc(1500);
        check_val("wig_ready", 32'(DISK_READY), 1);
        check_val("wig_loaded", 32'(TRACK_LOADED), 3);
        check_val("wig_reqs", 32'(rd_rises - base_rd + wr_rises - base_wr), 0);

        load_track(7'd5, "t5");

        // Write in READY, then step 5->6->7; 6 never settles.
        DRIVE_WE = 1'b1;
        cyc(1);
        DRIVE_WE = 1'b0;
        check_val("we_dirty", 32'(DIRTY), 32'(WB));
        base_rd = rd_rises;
        base_wr = wr_rises;
        DRIVE_TRACK = 7'd6;
        cyc(500);
        DRIVE_TRACK = 7'd7;
        wait_req(3000, n);
        if (WB == 1) begin
            check_val("fl_wr", 32'(HOST_WR), 1);
            check_val("fl_rd", 32'(HOST_RD), 0);
            check_val("fl_lba", 32'(LBA_TRACK), 5);
            ack(1'b0);
            check_val("fl_wr_drop", 32'(HOST_WR), 0);
            check_val("fl_dirty", 32'(DIRTY), 0);
        end
        check_val("ld7_rd", 32'(HOST_RD), 1);
        check_val("ld7_wr", 32'(HOST_WR), 0);
        check_val("ld7_lba", 32'(LBA_TRACK), 7);
        ack(1'b0);
        check_val("ld7_loaded", 32'(TRACK_LOADED), 7);
        check_val("ld7_dirty", 32'(DIRTY), 0);
        check_val("ld7_rd_rises", 32'(rd_rises - base_rd), 1);
        check_val("ld7_wr_rises", 32'(wr_rises - base_wr), 32'(WB));

        // Timeout: request high 16 cycles, drops one cycle, re-asserts.
        DRIVE_TRACK = 7'd9;
        wait_req(3000, n);
        check_val("to_lba", 32'(LBA_TRACK), 9);
        n = 0;
        while (HOST_RD && n < 100) begin
            cyc(1);
            n++;
        end
        check_val("to_high_cycles", 32'(n), 16);
        cyc(1);
        check_val("to_reassert", 32'(HOST_RD), 1);
        ack(1'b0);
        check_val("to_ready", 32'(DISK_READY), 1);
        check_val("to_loaded", 32'(TRACK_LOADED), 9);

        // Three error acks: two gaps, then ERROR. A good ack in a gap is ignored.
        DRIVE_TRACK = 7'd10;
        wait_req(3000, n);
        check_val("er_lba", 32'(LBA_TRACK), 10);
        ack(1'b1);
        check_val("er_gap1", 32'(HOST_RD), 0);
        ack(1'b0);
        check_val("er_gap_ack_ignored_rd", 32'(HOST_RD), 1);
        check_val("er_gap_ack_ignored_ready", 32'(DISK_READY), 0);
        ack(1'b1);
        check_val("er_gap2", 32'(HOST_RD), 0);
        cyc(1);
        check_val("er_reassert2", 32'(HOST_RD), 1);
        ack(1'b1);
        check_val("er_error", 32'(DISK_ERROR), 1);
        check_val("er_rd", 32'(HOST_RD), 0);
        check_val("er_busy", 32'(TRACK_BUSY), 1);
        check_val("er_ready", 32'(DISK_READY), 0);
        check_val("er_valid", 32'(LOADED_VALID), 0);
        cyc(5);
        check_val("er_hold", 32'(DISK_ERROR), 1);

        DISK_MOUNTED = 1'b0;
        cyc(1);
        check_val("um_err", 32'(DISK_ERROR), 0);
        check_val("um_busy", 32'(TRACK_BUSY), 1);
        check_val("um_valid", 32'(LOADED_VALID), 0);

        // Reset mid-transfer drops the request without a clock edge.
        DISK_MOUNTED = 1'b1;
        wait_req(3000, n);
        check_val("ar_lba", 32'(LBA_TRACK), 10);
        #10;
        RESET = 1'b1;
        #1;
        check_val("ar_rd_async", 32'(HOST_RD), 0);
        @(posedge CLK_14M);
        #1;
        RESET = 1'b0;
        ack(1'b0);
        check_val("ar_late_ack_rd", 32'(HOST_RD), 0);
        check_val("ar_late_ack_ready", 32'(DISK_READY), 0);
        check_val("ar_loaded", 32'(TRACK_LOADED), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/drive_track_sequencer.md
DRIVE_TRACK_SEQUENCER -- requirements
Module: drive_track_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1400; stable-track cycles (~100 us at 14 MHz) required before a track transfer starts.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 14000000; host-ack timeout per transfer attempt.
REQ-003 SHALL have parameter MAX_RETRIES, default 2; retries after the first failed attempt.
REQ-004 SHALL have ports: CLK_14M in 1, clock; RESET in 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports: DISK_MOUNTED in 1, image present; DRIVE_TRACK in 7, head track from drive; DRIVE_WE in 1, drive track-RAM write strobe.
REQ-006 SHALL have ports: TRACK_BUSY out 1, to drive; DISK_READY out 1, to drive; TRACK_LOADED out 7, track held in buffer; LOADED_VALID out 1; DIRTY out 1; DISK_ERROR out 1.
REQ-007 SHALL have ports: HOST_RD out 1, load request; HOST_WR out 1, writeback request; LBA_TRACK out 7, track being transferred; HOST_ACK in 1, one-cycle done pulse; HOST_ERR in 1, qualifies HOST_ACK as failed.

Function
REQ-008 SHALL implement states IDLE, SETTLE, FLUSH, LOAD, READY, ERROR; all outputs registered.
REQ-009 IDLE: DISK_MOUNTED=1 -> SETTLE, latch DRIVE_TRACK, clear settle counter.
REQ-010 SETTLE: counter increments while DRIVE_TRACK equals latch; on change, relatch and clear counter.
REQ-011 SETTLE at count SETTLE_CYCLES-1: LOADED_VALID=1 and latch==TRACK_LOADED -> READY; else DIRTY=1 -> FLUSH; else LOAD.
REQ-012 FLUSH: HOST_WR=1, LBA_TRACK=TRACK_LOADED; good ack -> clear DIRTY, go LOAD.
REQ-013 LOAD: HOST_RD=1, LBA_TRACK=latch; good ack -> TRACK_LOADED=latch, LOADED_VALID=1, go READY.
REQ-014 HOST_RD/HOST_WR SHALL deassert on the edge that samples HOST_ACK; never both high.
REQ-015 TRACK_BUSY=0 and DISK_READY=1 only in READY, first asserted the cycle after the good ack (or after settle match).
REQ-016 READY: DRIVE_WE=1 sets DIRTY; DRIVE_TRACK!=TRACK_LOADED -> SETTLE (relatch, clear counter); DRIVE_WE in that same cycle still sets DIRTY.
REQ-017 Failed attempt = HOST_ACK with HOST_ERR, or timeout counter reaching TIMEOUT_CYCLES-1 in FLUSH/LOAD.
REQ-018 On failure with retries left: drop request exactly one cycle, re-assert same request, increment retry count; retry and timeout counters clear on entry from SETTLE.
REQ-019 Failure after MAX_RETRIES retries -> ERROR: DISK_ERROR=1, TRACK_BUSY=1, DISK_READY=0, LOADED_VALID=0.
REQ-020 DISK_MOUNTED=0 in any state -> IDLE next edge: requests drop, LOADED_VALID, DIRTY, DISK_ERROR clear; pending flush is abandoned.
REQ-021 HOST_ACK outside FLUSH/LOAD, or in the one-cycle request gap, SHALL be ignored.
REQ-022 Counters SHALL saturate, never wrap; DRIVE_TRACK compared full 7 bits.

Reset
REQ-023 RESET SHALL force IDLE, TRACK_BUSY=1, DISK_READY=0, HOST_RD=0, HOST_WR=0, LBA_TRACK=0, TRACK_LOADED=0, LOADED_VALID=0, DIRTY=0, DISK_ERROR=0, all counters 0.
REQ-024 RESET mid-transfer SHALL drop requests immediately (asynchronous); late HOST_ACK after release ignored per REQ-021.

Configuration
REQ-025 Macro TRACK_WRITEBACK_EN defined: DIRTY tracking and FLUSH behave per REQ-012/016.
REQ-026 Macro TRACK_WRITEBACK_EN undefined: DRIVE_WE ignored, DIRTY and HOST_WR tied 0, FLUSH unreachable; track changes go straight to LOAD.

Verification
REQ-027 Reset, mount, DRIVE_TRACK=0 stable 1400 cycles -> HOST_RD=1, LBA_TRACK=0; ack -> next cycle DISK_READY=1, TRACK_BUSY=0, TRACK_LOADED=0.
REQ-028 READY on track 5, DRIVE_WE pulse, DRIVE_TRACK steps 5->6->7 every 500 cycles then holds -> single HOST_WR with LBA_TRACK=5, then HOST_RD LBA_TRACK=7; no transfer for 6.
REQ-029 LOAD, HOST_ACK+HOST_ERR three times -> two one-cycle request gaps, then ERROR with DISK_ERROR=1; DISK_MOUNTED=0 -> IDLE, DISK_ERROR=0.
REQ-030 LOAD with TIMEOUT_CYCLES=16, no ack -> request drops at cycle 16, re-asserts one cycle later.
REQ-031 Track 3 loaded, move to 4 and back to 3 within 100 cycles -> returns to READY after settle with no host request.
REQ-032 Build without TRACK_WRITEBACK_EN, DRIVE_WE pulses in READY, track change -> DIRTY=0, HOST_WR never asserted, HOST_RD issued.
